// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Two-master arbiter for the single-port cpu_ram. Master 0 is
//               the CPU bus path, master 1 the audio DMA engine. Grants are
//               round-robin, and an urgent flag lets master 1 win when the
//               audio FIFO is starving.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic [DATA_W-1:0]     m1_rdata,
    input  logic                  m1_urgent,

    output logic                  ram_valid,
    input  logic                  ram_ready,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [DATA_W/8-1:0]   ram_wstrb,
    input  logic [DATA_W-1:0]     ram_rdata,

    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                ram_valid_q, ram_valid_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [STRB_W-1:0]   ram_wstrb_q, ram_wstrb_d;

    // Master 1 wins an IDLE decision when it is the only requester, when it
    // is urgent, or on a tie where master 0 was served last.
    logic pick1;
    assign pick1 = m1_valid && (!m0_valid || m1_urgent || !last_q);

    // Next-state logic: arbitrate in IDLE, hold the request until the RAM acks.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        ram_valid_d = ram_valid_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wstrb_d = ram_wstrb_q;
        case (state_q)
            IDLE: begin
                if (pick1) begin
                    state_d     = GNT1;
                    ram_valid_d = 1'b1;
                    ram_addr_d  = m1_addr;
                    ram_wdata_d = m1_wdata;
                    ram_wstrb_d = m1_wstrb;
                end else if (m0_valid) begin
                    state_d     = GNT0;
                    ram_valid_d = 1'b1;
                    ram_addr_d  = m0_addr;
                    ram_wdata_d = m0_wdata;
                    ram_wstrb_d = m0_wstrb;
                end
            end
            GNT0: begin
                // The transfer always completes, even if master 0 withdrew.
                if (ram_ready) begin
                    state_d     = IDLE;
                    ram_valid_d = 1'b0;
                    last_d      = 1'b0;
                end
            end
            GNT1: begin
                if (ram_ready) begin
                    state_d     = IDLE;
                    ram_valid_d = 1'b0;
                    last_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                ram_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered RAM-side outputs; last resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            ram_valid_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            ram_valid_q <= ram_valid_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wstrb_q <= ram_wstrb_d;
        end
    end

    // Completion is combinational from ram_ready; a withdrawn master gets no ack.
    logic ack0, ack1;
    always_comb begin
        ack0     = (state_q == GNT0) && ram_ready && m0_valid;
        ack1     = (state_q == GNT1) && ram_ready && m1_valid;
        m0_ready = ack0;
        m1_ready = ack1;
        m0_rdata = ack0 ? ram_rdata : '0;
        m1_rdata = ack1 ? ram_rdata : '0;
    end

    assign ram_valid = ram_valid_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wstrb = ram_wstrb_q;
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-master arbiter sharing the single-port cpu_ram between the picorv32 bus path (master 0) and an audio DMA engine (master 1).
- Both masters and the RAM use the native valid/ready/addr/wdata/wstrb/rdata handshake.
- Selection is round-robin, with an urgent override for master 1 when the audio FIFO is starving.
- Sits between cpu_bus_logic's RAM port and the cpu_ram instance, on clk_soc.

Parameters:
ADDR_W, 15, RAM word-address width (matches cpu_ram addr)
DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
clk  in  1  system clock (clk_soc)
reset  in  1  synchronous, active-high reset
m0_valid  in  1  master 0 (CPU) request
m0_ready  out  1  master 0 transfer complete
m0_addr  in  ADDR_W  master 0 word address
m0_wdata  in  DATA_W  master 0 write data
m0_wstrb  in  DATA_W/8  master 0 byte strobes; 0 = read
m0_rdata  out  DATA_W  master 0 read data
m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  same directions/widths as m0_*, for master 1 (DMA)
m1_urgent  in  1  DMA urgent request; overrides round-robin
ram_valid  out  1  request to cpu_ram
ram_ready  in  1  cpu_ram completion
ram_addr  out  ADDR_W  to cpu_ram
ram_wdata  out  DATA_W  to cpu_ram
ram_wstrb  out  DATA_W/8  to cpu_ram
ram_rdata  in  DATA_W  from cpu_ram
busy  out  1  high while state != IDLE

Behaviour:
Reset (synchronous):
- state=IDLE, last=1 (so m0 wins the first tie).
- ram_valid=0; ram_addr, ram_wdata and ram_wstrb = 0.
- m0_ready=m1_ready=0; busy=0.

States:
- IDLE:
  - Only m0_valid: go to GNT0.
  - Only m1_valid: go to GNT1.
  - Both valid, m1_urgent=1: GNT1.
  - Both valid, m1_urgent=0: grant the master != last.
  - Neither valid: stay in IDLE.
- On entering GNTx (same edge):
  - Register the winner's addr/wdata/wstrb into ram_addr/ram_wdata/ram_wstrb.
  - Set ram_valid<=1.
- GNTx:
  - ram_valid and ram_* outputs held stable until ram_ready=1.
  - In the cycle ram_ready=1: mx_ready = mx_valid (combinational) and mx_rdata = ram_rdata.
  - At that edge: ram_valid<=0, last<=x, state<=IDLE.
  - The other master's ready stays 0 throughout.

Outputs outside grant:
- mx_rdata = 0 when not granted/acknowledged.
- busy = (state != IDLE).

Timing:
- Arbitration latency is 1 cycle: request seen in cycle N, ram_valid high in N+1.
- Completion is combinational from ram_ready.
- After a completion the arbiter spends 1 IDLE cycle before the next grant.
- Back-to-back throughput per master: one transfer per (RAM latency + 2) cycles.

Boundary conditions:
- Master drops valid while granted (protocol violation): the RAM transaction still runs to ram_ready (no abort). The ack is discarded (mx_ready=0) and last is updated normally.
- m1_urgent=1 with m1_valid=0: ignored.
- m1_urgent only affects the IDLE decision; it never preempts a grant in progress.
- Requests arriving while a grant is active wait. The waiting master wins the next IDLE decision if the other master re-requests, unless m1_urgent overrides in master 1's favour.
- ram_ready while IDLE: ignored, no ready generated.
- Reset mid-grant: outputs return to reset values at the next edge and the pending transfer is dropped.
- Write strobes pass through unmodified; reads are wstrb=0.

Test Plan:
- Single read m0: m0_valid, addr=0x0123, wstrb=0; RAM acks with rdata=0xDEADBEEF after 2 cycles -> ram_valid rises 1 cycle after m0_valid; ram_addr=0x0123; m0_ready=1 with m0_rdata=0xDEADBEEF in the ack cycle; m1_ready=0 throughout.
- Tie after reset: m0 and m1 valid in the same cycle, m1_urgent=0 -> m0 is served first, then m1; continuous requests from both alternate m0,m1,m0,m1 over 8 transfers.
- Urgent override: last=1, both valid, m1_urgent=1 -> m1 granted again ahead of m0; m0 is granted on the following IDLE cycle.
- Write passthrough: m1 writes addr=0x7FFF, wdata=0xA5A5A5A5, wstrb=4'b0101 -> identical values on the ram_* outputs, held stable across 3 wait cycles until ram_ready.
- Valid drop: m0 granted, m0_valid falls before ram_ready -> ram_valid stays high until ram_ready, m0_ready stays 0, state returns to IDLE.
- Reset mid-grant: assert reset during GNT1 with ram_valid=1 -> next edge gives ram_valid=0, busy=0, and m0 wins the subsequent tie.
